// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the 5-stage pipeline: load-use stalls, MEM-resolved
// branch flushes, data-memory wait freezes with a timeout watchdog.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   ID_EX_* / IF_ID_*   : load-use detection operands
//   EX_MEM_BranchTaken  : taken branch resolved in MEM
//   DMem_req/DMem_ready : data-memory handshake
//   PCWrite, IF_ID_Write, ID_EX_Bubble, *_Flush, Freeze : pipeline controls
//   MemTimeout          : sticky watchdog error flag
//   Stall_count         : saturating count of cycles with PCWrite=0
module pipeline_hazard_controller #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_RegisterRd,
   input  logic [4:0]       IF_ID_RegisterRn1,
   input  logic [4:0]       IF_ID_RegisterRm2,
   input  logic             IF_ID_UsesRm2,
   input  logic             EX_MEM_BranchTaken,
   input  logic             DMem_req,
   input  logic             DMem_ready,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             ID_EX_Bubble,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             EX_MEM_Flush,
   output logic             Freeze,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] Stall_count
);

   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic              mem_timeout_q, mem_timeout_d;
   logic              mem_stall;
   logic              rn1_hit, rm2_hit, load_use;

   assign mem_stall = DMem_req & ~DMem_ready;
   assign rn1_hit   = (ID_EX_RegisterRd == IF_ID_RegisterRn1);
   assign rm2_hit   = IF_ID_UsesRm2 & (ID_EX_RegisterRd == IF_ID_RegisterRm2);
   // XZR reads as zero, so a load targeting it never produces a dependency
   assign load_use  = ID_EX_MemRead & (ID_EX_RegisterRd != 5'd31)
                    & (rn1_hit | rm2_hit);
   assign wait_inc  = wait_q + 1'b1;

   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      mem_timeout_d = mem_timeout_q;
      stall_cnt_d   = stall_cnt_q;
      PCWrite       = 1'b1;
      IF_ID_Write   = 1'b1;
      ID_EX_Bubble  = 1'b0;
      IF_ID_Flush   = 1'b0;
      ID_EX_Flush   = 1'b0;
      EX_MEM_Flush  = 1'b0;
      Freeze        = 1'b0;

      unique case (state_q)
         RUN: begin
            unique case (1'b1)
               mem_stall: begin
                  Freeze      = 1'b1;
                  PCWrite     = 1'b0;
                  IF_ID_Write = 1'b0;
                  state_d     = MEM_WAIT;
                  wait_d      = WAIT_W'(1);
               end
               (~mem_stall & EX_MEM_BranchTaken): begin
                  IF_ID_Flush  = 1'b1;
                  ID_EX_Flush  = 1'b1;
                  EX_MEM_Flush = 1'b1;
               end
               (~mem_stall & ~EX_MEM_BranchTaken & load_use): begin
                  PCWrite      = 1'b0;
                  IF_ID_Write  = 1'b0;
                  ID_EX_Bubble = 1'b1;
               end
               default: ;
            endcase
         end
         MEM_WAIT: begin
            // a taken branch held in EX/MEM waits until release
            Freeze      = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            if (DMem_ready) begin
               state_d = RUN;
               wait_d  = '0;
            end else begin
               wait_d = wait_inc;
               if (wait_inc >= WAIT_W'(TIMEOUT)) begin
                  state_d       = ERROR;
                  mem_timeout_d = 1'b1;
               end
            end
         end
         ERROR: begin
            Freeze        = 1'b1;
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            mem_timeout_d = 1'b1;
         end
         default: state_d = RUN;
      endcase

      if (!PCWrite && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end

      if (reset) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Bubble = 1'b0;
         IF_ID_Flush  = 1'b1;
         ID_EX_Flush  = 1'b1;
         EX_MEM_Flush = 1'b1;
         Freeze       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= RUN;
         wait_q        <= '0;
         mem_timeout_q <= 1'b0;
         stall_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         mem_timeout_q <= mem_timeout_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   assign MemTimeout  = mem_timeout_q;
   assign Stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: default, TIMEOUT=4 and
// CNT_W=4 instances share stimulus; each scenario task checks inline.
module tb_pipeline_hazard_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       memread;
   logic [4:0] rd, rn1, rm2;
   logic       uses_rm2, br, req, rdy;

   logic        a_pcw, a_ifw, a_bub, a_iff, a_idf, a_exf, a_frz, a_mto;
   logic [15:0] a_cnt;
   logic        t_pcw, t_ifw, t_bub, t_iff, t_idf, t_exf, t_frz, t_mto;
   logic [15:0] t_cnt;
   logic        c_pcw, c_ifw, c_bub, c_iff, c_idf, c_exf, c_frz, c_mto;
   logic [3:0]  c_cnt;

   logic [7:0] ctl_a, ctl_t, ctl_c;
   assign ctl_a = {a_pcw, a_ifw, a_bub, a_iff, a_idf, a_exf, a_frz, a_mto};
   assign ctl_t = {t_pcw, t_ifw, t_bub, t_iff, t_idf, t_exf, t_frz, t_mto};
   assign ctl_c = {c_pcw, c_ifw, c_bub, c_iff, c_idf, c_exf, c_frz, c_mto};

   // {PCWrite, IF_ID_Write, Bubble, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
   //  Freeze, MemTimeout}
   localparam logic [7:0] DEF  = 8'b1100_0000;
   localparam logic [7:0] LU   = 8'b0010_0000;
   localparam logic [7:0] BR   = 8'b1101_1100;
   localparam logic [7:0] FRZ  = 8'b0000_0010;
   localparam logic [7:0] ERRV = 8'b0000_0011;
   localparam logic [7:0] RST  = 8'b0001_1100;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   pipeline_hazard_controller u_a (
      .clk(clk), .reset(reset),
      .ID_EX_MemRead(memread), .ID_EX_RegisterRd(rd),
      .IF_ID_RegisterRn1(rn1), .IF_ID_RegisterRm2(rm2),
      .IF_ID_UsesRm2(uses_rm2), .EX_MEM_BranchTaken(br),
      .DMem_req(req), .DMem_ready(rdy),
      .PCWrite(a_pcw), .IF_ID_Write(a_ifw), .ID_EX_Bubble(a_bub),
      .IF_ID_Flush(a_iff), .ID_EX_Flush(a_idf), .EX_MEM_Flush(a_exf),
      .Freeze(a_frz), .MemTimeout(a_mto), .Stall_count(a_cnt)
   );

   pipeline_hazard_controller #(.TIMEOUT(4)) u_t (
      .clk(clk), .reset(reset),
      .ID_EX_MemRead(memread), .ID_EX_RegisterRd(rd),
      .IF_ID_RegisterRn1(rn1), .IF_ID_RegisterRm2(rm2),
      .IF_ID_UsesRm2(uses_rm2), .EX_MEM_BranchTaken(br),
      .DMem_req(req), .DMem_ready(rdy),
      .PCWrite(t_pcw), .IF_ID_Write(t_ifw), .ID_EX_Bubble(t_bub),
      .IF_ID_Flush(t_iff), .ID_EX_Flush(t_idf), .EX_MEM_Flush(t_exf),
      .Freeze(t_frz), .MemTimeout(t_mto), .Stall_count(t_cnt)
   );

   pipeline_hazard_controller #(.CNT_W(4)) u_c (
      .clk(clk), .reset(reset),
      .ID_EX_MemRead(memread), .ID_EX_RegisterRd(rd),
      .IF_ID_RegisterRn1(rn1), .IF_ID_RegisterRm2(rm2),
      .IF_ID_UsesRm2(uses_rm2), .EX_MEM_BranchTaken(br),
      .DMem_req(req), .DMem_ready(rdy),
      .PCWrite(c_pcw), .IF_ID_Write(c_ifw), .ID_EX_Bubble(c_bub),
      .IF_ID_Flush(c_iff), .ID_EX_Flush(c_idf), .EX_MEM_Flush(c_exf),
      .Freeze(c_frz), .MemTimeout(c_mto), .Stall_count(c_cnt)
   );

   // inputs change 1 time unit after a rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      memread  = 1'b0;
      rd       = 5'd0;
      rn1      = 5'd0;
      rm2      = 5'd0;
      uses_rm2 = 1'b0;
      br       = 1'b0;
      req      = 1'b0;
      rdy      = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_in();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      clear_in();
      memread = 1'b1; rd = 5'd3; rn1 = 5'd3;
      tick();
      #2;
      vecs++;
      if (ctl_a !== RST) begin
         errs++;
         $display("FAIL reset_ctl got %b want %b", ctl_a, RST);
      end
      vecs++;
      if (a_cnt !== 16'd0) begin
         errs++;
         $display("FAIL reset_cnt got %0d want 0", a_cnt);
      end
      tick();
      reset = 1'b0;
      clear_in();
      #2;
      vecs++;
      if (ctl_a !== DEF) begin
         errs++;
         $display("FAIL idle_ctl got %b want %b", ctl_a, DEF);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      memread = 1'b1; rd = 5'd3; rn1 = 5'd3;
      #2;
      vecs++;
      if (ctl_a !== LU) begin
         errs++;
         $display("FAIL lu_stall got %b want %b", ctl_a, LU);
      end
      tick();
      memread = 1'b0;
      #2;
      vecs++;
      if (ctl_a !== DEF) begin
         errs++;
         $display("FAIL lu_release got %b want %b", ctl_a, DEF);
      end
      vecs++;
      if (a_cnt !== 16'd1) begin
         errs++;
         $display("FAIL lu_cnt got %0d want 1", a_cnt);
      end
      memread = 1'b1; rd = 5'd31; rn1 = 5'd31;
      #2;
      vecs++;
      if (ctl_a !== DEF) begin
         errs++;
         $display("FAIL lu_xzr got %b want %b", ctl_a, DEF);
      end
      tick();
      vecs++;
      if (a_cnt !== 16'd1) begin
         errs++;
         $display("FAIL lu_xzr_cnt got %0d want 1", a_cnt);
      end
   endtask

   task automatic test_rm2();
      do_reset();
      memread = 1'b1; rd = 5'd3; rn1 = 5'd5; rm2 = 5'd3; uses_rm2 = 1'b0;
      #2;
      vecs++;
      if (ctl_a !== DEF) begin
         errs++;
         $display("FAIL rm2_unused got %b want %b", ctl_a, DEF);
      end
      uses_rm2 = 1'b1;
      #1;
      vecs++;
      if (ctl_a !== LU) begin
         errs++;
         $display("FAIL rm2_used got %b want %b", ctl_a, LU);
      end
      tick();
      vecs++;
      if (a_cnt !== 16'd1) begin
         errs++;
         $display("FAIL rm2_cnt got %0d want 1", a_cnt);
      end
   endtask

   task automatic test_branch_priority();
      do_reset();
      memread = 1'b1; rd = 5'd3; rn1 = 5'd3; br = 1'b1;
      #2;
      vecs++;
      if (ctl_a !== BR) begin
         errs++;
         $display("FAIL br_over_lu got %b want %b", ctl_a, BR);
      end
      tick();
      vecs++;
      if (a_cnt !== 16'd0) begin
         errs++;
         $display("FAIL br_cnt got %0d want 0", a_cnt);
      end
   endtask

   task automatic test_mem_wait();
      do_reset();
      req = 1'b1; rdy = 1'b0; br = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) rdy = 1'b1;
         #2;
         vecs++;
         if (ctl_a !== FRZ) begin
            errs++;
            $display("FAIL wait_frz[%0d] got %b want %b", i, ctl_a, FRZ);
         end
         tick();
      end
      req = 1'b0; rdy = 1'b0;
      #2;
      vecs++;
      if (ctl_a !== BR) begin
         errs++;
         $display("FAIL wait_br_after got %b want %b", ctl_a, BR);
      end
      vecs++;
      if (a_cnt !== 16'd4) begin
         errs++;
         $display("FAIL wait_cnt got %0d want 4", a_cnt);
      end
      vecs++;
      if (ctl_t !== BR) begin
         errs++;
         $display("FAIL wait_t4_noerr got %b want %b", ctl_t, BR);
      end
      tick();
      br = 1'b0; req = 1'b1; rdy = 1'b1;
      #2;
      vecs++;
      if (ctl_a !== DEF) begin
         errs++;
         $display("FAIL single_cycle got %b want %b", ctl_a, DEF);
      end
      tick();
      vecs++;
      if (a_cnt !== 16'd4) begin
         errs++;
         $display("FAIL single_cnt got %0d want 4", a_cnt);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      req = 1'b1; rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #2;
         vecs++;
         if (ctl_t !== FRZ) begin
            errs++;
            $display("FAIL to_wait[%0d] got %b want %b", i, ctl_t, FRZ);
         end
         tick();
      end
      #2;
      vecs++;
      if (ctl_t !== ERRV) begin
         errs++;
         $display("FAIL to_error got %b want %b", ctl_t, ERRV);
      end
      vecs++;
      if (t_cnt !== 16'd4) begin
         errs++;
         $display("FAIL to_cnt got %0d want 4", t_cnt);
      end
      vecs++;
      if (ctl_a !== FRZ) begin
         errs++;
         $display("FAIL to_default_wait got %b want %b", ctl_a, FRZ);
      end
      rdy = 1'b1;
      tick();
      #2;
      vecs++;
      if (ctl_t !== ERRV) begin
         errs++;
         $display("FAIL to_sticky got %b want %b", ctl_t, ERRV);
      end
      vecs++;
      if (t_cnt !== 16'd5) begin
         errs++;
         $display("FAIL to_cnt2 got %0d want 5", t_cnt);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      clear_in();
      #2;
      vecs++;
      if (ctl_t !== DEF) begin
         errs++;
         $display("FAIL to_reset got %b want %b", ctl_t, DEF);
      end
      vecs++;
      if (t_cnt !== 16'd0) begin
         errs++;
         $display("FAIL to_reset_cnt got %0d want 0", t_cnt);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      memread = 1'b1; rd = 5'd7; rn1 = 5'd7;
      for (int i = 0; i < 14; i++) tick();
      vecs++;
      if (c_cnt !== 4'd14) begin
         errs++;
         $display("FAIL sat_14 got %0d want 14", c_cnt);
      end
      for (int i = 0; i < 6; i++) tick();
      vecs++;
      if (c_cnt !== 4'd15) begin
         errs++;
         $display("FAIL sat_hold got %0d want 15", c_cnt);
      end
      vecs++;
      if (a_cnt !== 16'd20) begin
         errs++;
         $display("FAIL sat_wide got %0d want 20", a_cnt);
      end
      vecs++;
      if (ctl_c !== LU) begin
         errs++;
         $display("FAIL sat_ctl got %b want %b", ctl_c, LU);
      end
   endtask

   initial begin
      reset = 1'b1;
      clear_in();
      #1;
      test_reset();
      test_load_use();
      test_rm2();
      test_branch_priority();
      test_mem_wait();
      test_timeout();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
